calc_bank: RTL
==============

Name: calc_bank

Overview:
- Parametrised successor to the single-accumulator button calculator.
- Holds a bank of NUM_ACC signed accumulators of WIDTH bits and contains its own ALU.
- Debounces the commit button with a press/release FSM, so each physical press updates the selected accumulator exactly once.
- Tracks a sticky signed-overflow flag per accumulator. Sits between the board buttons/switches and the LED display.

Parameters:
- WIDTH, 16, accumulator/operand/LED width; must be ≥ 4.
- NUM_ACC, 4, number of accumulators; power of two, ≥ 2.
- DEBOUNCE, 4, consecutive stable synchronised samples needed to accept a press or release; must be ≥ 2.
- Derived: SELW = $clog2(NUM_ACC); SHW = $clog2(WIDTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- btnu  in  1  reset, synchronous, active-high.
- btnd  in  1  commit button, raw and asynchronous.
- btnl  in  1  op select bit 2, level.
- btnc  in  1  op select bit 1, level.
- btnr  in  1  op select bit 0, level.
- sw  in  WIDTH  operand B, two's complement.
- acc_sel  in  SELW  accumulator index, used for both update and display.
- led  out  WIDTH  value of acc[acc_sel].
- zero  out  1  high when led == 0.
- ovf  out  1  sticky overflow flag of acc[acc_sel].
- done  out  1  one-cycle strobe, registered.

Behaviour:
- Reset (btnu=1 at an edge):
  - acc[*]=0, ovf_flag[*]=0, FSM=IDLE, cnt=0, synchroniser flops=0, done=0.
  - Reset has priority over any commit in the same cycle.
  - After reset: led=0, zero=1, ovf=0.
- Synchronisation: btnd passes a 2-flop synchroniser → btnd_s. btnl/btnc/btnr/sw/acc_sel are not synchronised; the operator holds them stable while pressing.
- Debounce FSM (cnt is DEBOUNCE-sized):
  - IDLE: btnd_s=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: btnd_s=0 → IDLE, cnt=0. Else if cnt==DEBOUNCE-1 → HELD and commit at this edge. Else cnt++.
  - HELD: btnd_s=0 → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: btnd_s=1 → HELD, no commit. Else if cnt==DEBOUNCE-1 → IDLE. Else cnt++.
- Latency: raw btnd first sampled high at edge k → commit at edge k+DEBOUNCE+1. led shows the new value after that edge. done=1 for exactly the following cycle.
- Commit: at the commit edge, sample op={btnl,btnc,btnr}, a=acc[acc_sel], b=sw. Write acc[acc_sel] ← result. All other accumulators are untouched.
- ALU (WIDTH-bit, result truncated to WIDTH):
  - 000 add a+b, wraps.
  - 001 sub a−b, wraps.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 sll: a << b[SHW-1:0].
  - 110 sra: arithmetic a >>> b[SHW-1:0].
  - 111 slt: signed (a<b) ? 1 : 0.
- Overflow:
  - add sets ovf_flag[acc_sel] when a and b have the same sign and the result sign differs.
  - sub sets it when a and b have different signs and the result sign differs from a.
  - Other ops never set or clear it. The flag is sticky until reset.
- Outputs: led, zero and ovf are combinational muxes of registered state by acc_sel. Changing acc_sel changes the display the same cycle with no state change.
- Boundary cases:
  - acc_sel change during HELD causes no extra commit.
  - Bounce shorter than DEBOUNCE samples in PRESS_WAIT yields no commit.
  - A low glitch shorter than DEBOUNCE samples in HELD yields no second commit.
  - Reset mid-press discards the pending press. If btnd is still high after btnu drops, it counts as a new press and commits once after the full latency, measured from the first edge with btnu=0.

Test Plan (WIDTH=16, NUM_ACC=4, DEBOUNCE=4):
1. Reset; acc_sel=0, op=000, sw=0x0005; hold btnd 12 cycles, release 8, press again → led=0x0005 after edge k+5, done high exactly 1 cycle; after second press led=0x000A, two done pulses total.
2. btnd high 2 cycles, low 1, high 2, low 10 → no commit, led=0x0000, zero=1, done never asserted.
3. acc0: add 0x7FFF, then add 0x0001 → led=0x8000, ovf=1; then and with 0xFFFF → ovf stays 1; acc_sel=1 → led=0x0000, ovf=0.
4. acc_sel=1: add 0xFFFD → 0xFFFD; sra sw=0x0001 → 0xFFFE; slt sw=0x0000 → 0x0001; acc_sel=0 still holds its earlier value.
5. btnd held; assert btnu for 1 cycle while FSM is in PRESS_WAIT (cnt=2) → no commit, all accumulators 0. btnd kept high → exactly one commit 5 edges after btnu drops.
6. During HELD, drive btnd low for 2 cycles then high → no second commit or done. Release for ≥6 cycles → FSM returns to IDLE; the next press commits normally.

Source files
------------

// File: rtl/calc_bank.sv
`default_nettype none
// ============================================================================
// Module      : calc_bank
// Description : Bank of NUM_ACC signed accumulators with a built-in ALU. A
//               debounced commit button applies one operation per physical
//               press to the selected accumulator. Each accumulator also keeps
//               a sticky signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_bank #(
    parameter  int WIDTH    = 16,
    parameter  int NUM_ACC  = 4,
    parameter  int DEBOUNCE = 4,
    localparam int SELW     = $clog2(NUM_ACC),
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             btnu,
    input  logic             btnd,
    input  logic             btnl,
    input  logic             btnc,
    input  logic             btnr,
    input  logic [WIDTH-1:0] sw,
    input  logic [SELW-1:0]  acc_sel,
    output logic [WIDTH-1:0] led,
    output logic             zero,
    output logic             ovf,
    output logic             done
);

    localparam int             CNTW          = $clog2(DEBOUNCE + 1);
    localparam logic [CNTW-1:0] C_CNT_MAX    = CNTW'(DEBOUNCE - 1);
    localparam logic [CNTW-1:0] C_CNT_ONE    = CNTW'(1);

    localparam logic [1:0] C_ST_IDLE         = 2'd0;
    localparam logic [1:0] C_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] C_ST_HELD         = 2'd2;
    localparam logic [1:0] C_ST_RELEASE_WAIT = 2'd3;

    localparam logic [2:0] C_OP_ADD = 3'b000;
    localparam logic [2:0] C_OP_SUB = 3'b001;
    localparam logic [2:0] C_OP_AND = 3'b010;
    localparam logic [2:0] C_OP_OR  = 3'b011;
    localparam logic [2:0] C_OP_XOR = 3'b100;
    localparam logic [2:0] C_OP_SLL = 3'b101;
    localparam logic [2:0] C_OP_SRA = 3'b110;
    localparam logic [2:0] C_OP_SLT = 3'b111;

    logic             r_sync1;
    logic             r_btnd_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic             w_commit;

    logic [WIDTH-1:0] r_acc [NUM_ACC];
    logic [NUM_ACC-1:0] r_ovf;
    logic             r_done;

    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf_set;

    // Two-flop synchroniser for the asynchronous commit button
    always_ff @(posedge clk) begin
        if (btnu) begin
            r_sync1  <= 1'b0;
            r_btnd_s <= 1'b0;
        end else begin
            r_sync1  <= btnd;
            r_btnd_s <= r_sync1;
        end
    end

    // Debounce FSM state and stability counter registers
    always_ff @(posedge clk) begin
        if (btnu) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a level must stay stable DEBOUNCE samples to be accepted
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_ST_IDLE: begin
                if (r_btnd_s) begin
                    w_state_nxt = C_ST_PRESS_WAIT;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            C_ST_PRESS_WAIT: begin
                if (!r_btnd_s) begin
                    w_state_nxt = C_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = C_ST_HELD;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
            C_ST_HELD: begin
                if (!r_btnd_s) begin
                    w_state_nxt = C_ST_RELEASE_WAIT;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            default: begin
                if (r_btnd_s) begin
                    w_state_nxt = C_ST_HELD;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_state_nxt = C_ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + C_CNT_ONE;
                end
            end
        endcase
    end

    // Commit fires on the edge that accepts a stable press
    always_comb begin
        w_commit = (r_state == C_ST_PRESS_WAIT) && r_btnd_s && (r_cnt == C_CNT_MAX);
    end

    // ALU on the selected accumulator and the switch operand
    always_comb begin
        w_op      = {btnl, btnc, btnr};
        w_a       = r_acc[acc_sel];
        w_b       = sw;
        w_shamt   = sw[SHW-1:0];
        w_res     = '0;
        w_ovf_set = 1'b0;
        case (w_op)
            C_OP_ADD: begin
                w_res     = w_a + w_b;
                w_ovf_set = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            C_OP_SUB: begin
                w_res     = w_a - w_b;
                w_ovf_set = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            C_OP_AND: w_res = w_a & w_b;
            C_OP_OR:  w_res = w_a | w_b;
            C_OP_XOR: w_res = w_a ^ w_b;
            C_OP_SLL: w_res = w_a << w_shamt;
            C_OP_SRA: w_res = $signed(w_a) >>> w_shamt;
            C_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default:  w_res = '0;
        endcase
    end

    // Accumulator bank, sticky overflow flags and the done strobe
    always_ff @(posedge clk) begin
        if (btnu) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_acc[acc_sel] <= w_res;
                if (w_ovf_set) begin
                    r_ovf[acc_sel] <= 1'b1;
                end
            end
        end
    end

    // Display follows acc_sel combinationally
    always_comb begin
        led  = r_acc[acc_sel];
        zero = (r_acc[acc_sel] == '0);
        ovf  = r_ovf[acc_sel];
        done = r_done;
    end

endmodule
`default_nettype wire
